trigger_capture: RTL and testbench



---
 rtl/trigger_capture.sv | 132 +++++++++++++
 tb/tb_trigger_capture.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : trigger_capture
// Purpose  : Arms on request, triggers on a rising level crossing or timeout,
//            and freezes one frame of decimated samples for column readout.
// Revision : 1.0  initial release
// ============================================================================
module trigger_capture #(
    parameter int DEPTH    = 480,
    parameter int WIDTH    = 12,
    parameter int DECIMATE = 1,
    parameter int TIMEOUT  = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] sampleIn,
    input  logic                    sampleValid,
    input  logic signed [WIDTH-1:0] triggerLevel,
    input  logic                    autoMode,
    input  logic                    armRequest,
    input  logic [8:0]              readAddress,
    output logic [WIDTH-1:0]        readData,
    output logic                    captureDone,
    output logic                    busy
);
    localparam int             c_addrW       = 9;
    localparam int             c_timeoutW    = $clog2(TIMEOUT + 1);
    localparam logic [8:0]     c_lastAddr    = 9'(DEPTH - 1);
    localparam logic [7:0]     c_decLast     = 8'(DECIMATE - 1);
    localparam logic [7:0]     c_decAfterTrg = (DECIMATE > 1) ? 8'd1 : 8'd0;
    localparam logic [c_timeoutW-1:0] c_timeoutLast = c_timeoutW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [WIDTH-1:0]        r_ram [DEPTH];
    logic [WIDTH-1:0]        r_readData;
    logic                    r_captureDone;
    logic                    r_busy;
    logic signed [WIDTH-1:0] r_prevSample;
    logic                    r_prevValid;
    logic [c_timeoutW-1:0]   r_timeout;
    logic [7:0]              r_dec;
    logic [c_addrW-1:0]      r_writeAddress;
    logic                    w_levelTrig;
    logic                    w_autoTrig;
    logic                    w_trigger;
    logic                    w_write;
    logic                    w_enterArmed;
    logic [c_addrW-1:0]      w_writeAddr;

    always_comb begin
        w_levelTrig  = r_prevValid && (r_prevSample < triggerLevel) && (sampleIn >= triggerLevel);
        w_autoTrig   = autoMode && (r_timeout == c_timeoutLast);
        w_trigger    = (r_state == ARMED) && sampleValid && (w_levelTrig || w_autoTrig);
        // The trigger sample itself is frame entry 0, so it always writes.
        w_write      = !reset && (w_trigger ||
                       ((r_state == CAPTURE) && sampleValid && (r_dec == 8'd0)));
        w_writeAddr  = w_trigger ? '0 : r_writeAddress;
        w_enterArmed = armRequest && ((r_state == IDLE) || (r_state == DONE));

        w_nextState = r_state;
        case (r_state)
            IDLE:    if (armRequest) w_nextState = ARMED;
            ARMED:   if (w_trigger) w_nextState = (DEPTH == 1) ? DONE : CAPTURE;
            CAPTURE: if (w_write && (r_writeAddress == c_lastAddr)) w_nextState = DONE;
            DONE:    if (armRequest) w_nextState = ARMED;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_captureDone  <= 1'b0;
            r_busy         <= 1'b0;
            r_prevSample   <= '0;
            r_prevValid    <= 1'b0;
            r_timeout      <= '0;
            r_dec          <= '0;
            r_writeAddress <= '0;
        end else begin
            r_state       <= w_nextState;
            r_captureDone <= (w_nextState == DONE);
            r_busy        <= (w_nextState == ARMED) || (w_nextState == CAPTURE);

            if (sampleValid) r_prevSample <= sampleIn;

            // Timeout counter saturates so a long wait with autoMode off cannot wrap.
            if (w_enterArmed) begin
                r_prevValid <= 1'b0;
                r_timeout   <= '0;
            end else if (sampleValid) begin
                r_prevValid <= 1'b1;
                if ((r_state == ARMED) && (r_timeout != c_timeoutLast))
                    r_timeout <= r_timeout + 1'b1;
            end

            if (w_trigger)
                r_dec <= c_decAfterTrg;
            else if ((r_state == CAPTURE) && sampleValid)
                r_dec <= (r_dec == c_decLast) ? 8'd0 : r_dec + 8'd1;

            if (w_write) r_writeAddress <= w_writeAddr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_write) r_ram[w_writeAddr] <= sampleIn;
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_readData <= '0;
        else if ({1'b0, readAddress} < 10'(DEPTH))
            r_readData <= r_ram[readAddress];
        else
            r_readData <= '0;
    end

    assign readData    = r_readData;
    assign captureDone = r_captureDone;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trigger_capture
// Purpose  : Drives two capture instances (decimate 1 and 4) from one stimulus
//            stream and compares them with a frame-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_trigger_capture;
    localparam int DEPTH   = 480;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sIn;
    logic        sv;
    logic [11:0] lvlIn;
    logic        auto;
    logic        arm;
    logic [8:0]  rdAddr;
    logic [11:0] rdA, rdB;
    logic        doneA, doneB, busyA, busyB;

    int errors = 0;
    int checks = 0;
    int sInt   = 0;
    int lvl    = 0;

    // Reference model: frame bookkeeping per instance (0 idle, 1 armed, 2 capture, 3 done)
    int          decOf [2] = '{1, 4};
    logic [11:0] mem   [2][DEPTH];
    bit          known [2][DEPTH];
    int          mState[2];
    int          armCnt[2];
    int          capCnt[2];
    int          lastS [2];
    logic [11:0] expRd [2];
    bit          expKnown[2];

    always #5 clk = ~clk;

    trigger_capture #(.DEPTH(DEPTH), .WIDTH(12), .DECIMATE(1), .TIMEOUT(TIMEOUT)) dutA (
        .clock(clk), .reset(rst), .sampleIn(sIn), .sampleValid(sv), .triggerLevel(lvlIn),
        .autoMode(auto), .armRequest(arm), .readAddress(rdAddr), .readData(rdA),
        .captureDone(doneA), .busy(busyA));

    trigger_capture #(.DEPTH(DEPTH), .WIDTH(12), .DECIMATE(4), .TIMEOUT(TIMEOUT)) dutB (
        .clock(clk), .reset(rst), .sampleIn(sIn), .sampleValid(sv), .triggerLevel(lvlIn),
        .autoMode(auto), .armRequest(arm), .readAddress(rdAddr), .readData(rdB),
        .captureDone(doneB), .busy(busyB));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic store(input int d, input int k, input int s);
        mem[d][k]   = 12'(s);
        known[d][k] = 1'b1;
    endtask

    task automatic modelStep();
        int  a;
        bit  hit;
        for (int d = 0; d < 2; d++) begin
            a = int'(rdAddr);
            if (a >= DEPTH) begin
                expRd[d] = '0; expKnown[d] = 1'b1;
            end else begin
                expRd[d] = mem[d][a]; expKnown[d] = known[d][a];
            end
            if (rst) begin
                mState[d] = 0; expRd[d] = '0; expKnown[d] = 1'b1;
                continue;
            end
            case (mState[d])
                0, 3: if (arm) begin mState[d] = 1; armCnt[d] = 0; end
                1: if (sv) begin
                    hit = (armCnt[d] > 0 && lastS[d] < lvl && sInt >= lvl) ||
                          (auto && armCnt[d] >= TIMEOUT - 1);
                    armCnt[d]++;
                    if (hit) begin
                        capCnt[d] = 0; store(d, 0, sInt); mState[d] = 2;
                    end
                end
                2: if (sv) begin
                    capCnt[d]++;
                    if (capCnt[d] % decOf[d] == 0) begin
                        store(d, capCnt[d] / decOf[d], sInt);
                        if (capCnt[d] / decOf[d] == DEPTH - 1) mState[d] = 3;
                    end
                end
                default: ;
            endcase
            if (sv) lastS[d] = sInt;
        end
    endtask

    task automatic checkAll();
        check("busyA", 32'(busyA), 32'(mState[0] == 1 || mState[0] == 2));
        check("busyB", 32'(busyB), 32'(mState[1] == 1 || mState[1] == 2));
        check("doneA", 32'(doneA), 32'(mState[0] == 3));
        check("doneB", 32'(doneB), 32'(mState[1] == 3));
        if (expKnown[0]) check("readA", 32'(rdA), 32'(expRd[0]));
        if (expKnown[1]) check("readB", 32'(rdB), 32'(expRd[1]));
    endtask

    task automatic cycle(input bit v, input int s, input bit a, input int ra);
        @(negedge clk);
        sv = v; sInt = s; sIn = 12'(s); arm = a; rdAddr = 9'(ra);
        lvlIn = 12'(lvl);
        @(posedge clk);
        modelStep();
        #1 checkAll();
    endtask

    task automatic fillUntilDone(input int bound);
        int n = 0;
        while (!(doneA && doneB) && n < bound) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)) - 2048, 1'b0,
                  int'($urandom_range(0, 511)));
            n++;
        end
        check("frame_done", 32'(doneA && doneB), 32'd1);
    endtask

    initial begin
        int  r;
        int  n;
        bit  v;
        bit  a;
        rst = 1'b1; sv = 1'b0; sIn = '0; lvlIn = '0; auto = 1'b0; arm = 1'b0; rdAddr = '0;
        for (int d = 0; d < 2; d++) begin
            mState[d] = 0; armCnt[d] = 0; capCnt[d] = 0; lastS[d] = 0;
            for (int k = 0; k < DEPTH; k++) known[d][k] = 1'b0;
        end

        // Reset state
        repeat (3) cycle(0, 0, 0, 7);
        check("reset_readA", 32'(rdA), 32'd0);
        check("reset_busyA", 32'(busyA), 32'd0);
        rst = 1'b0;

        // Level crossing at 0: -100, -1, 0, 5
        lvl = 0;
        cycle(0, 0, 1, 0);
        check("arm_busyA", 32'(busyA), 32'd1);
        cycle(1, -100, 0, 0);
        cycle(1, -1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 5, 0, 0);
        fillUntilDone(8000);
        cycle(0, 0, 0, 0);
        check("t1_ramA0", 32'(rdA), 32'd0);
        check("t1_ramB0", 32'(rdB), 32'd0);
        cycle(0, 0, 0, 1);
        check("t1_ramA1", 32'(rdA), 32'd5);

        // No crossing on steady +50, then forced trigger by timeout
        cycle(0, 0, 1, 3);
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 1) == 1) cycle(0, 0, 0, 3);
            cycle(1, 50, 0, 3);
        end
        check("t2_armedA", 32'(busyA && !doneA), 32'd1);
        auto = 1'b1;
        cycle(1, 50, 0, 3);
        cycle(1, 50, 0, 3);
        auto = 1'b0;
        fillUntilDone(8000);
        cycle(0, 0, 0, 0);
        check("t2_autoA0", 32'(rdA), 32'd50);
        check("t2_autoB0", 32'(rdB), 32'd50);

        // Ramp with arm pulses mid-capture and on the final write of instance A
        cycle(0, 0, 1, 0);
        cycle(1, -3, 0, 0);
        r = 0; n = 0;
        while (!(doneA && doneB) && n < 4000) begin
            v = $urandom_range(0, 3) != 0;
            a = (n == 150) || (v && mState[0] == 2 && capCnt[0] == DEPTH - 2);
            cycle(v, r, a, int'($urandom_range(0, 511)));
            if (v) r++;
            n++;
        end
        check("t3_done", 32'(doneA && doneB), 32'd1);
        for (int k = 0; k < DEPTH; k++) begin
            cycle(0, 0, 0, k);
            check("rampA", 32'(rdA), 32'(k));
            check("rampB", 32'(rdB), 32'(4 * k));
        end
        cycle(0, 0, 1, 5);
        check("rearm_busyA", 32'(busyA), 32'd1);
        check("rearm_doneA", 32'(doneA), 32'd0);
        cycle(0, 0, 0, 5);
        check("rearm_keepB", 32'(rdB), 32'd20);

        // Reset with writeAddress at 200
        cycle(1, -3, 0, 0);
        r = 0; n = 0;
        while (!(mState[0] == 2 && capCnt[0] == 199) && n < 1000) begin
            v = $urandom_range(0, 3) != 0;
            cycle(v, r, 0, 0);
            if (v) r++;
            n++;
        end
        check("t5_reach200", 32'(capCnt[0]), 32'd199);
        rst = 1'b1;
        cycle(1, 9, 0, 150);
        rst = 1'b0;
        check("t5_busyA", 32'(busyA), 32'd0);
        check("t5_doneA", 32'(doneA), 32'd0);
        check("t5_readA", 32'(rdA), 32'd0);
        cycle(0, 0, 0, 150);
        check("t5_keepA", 32'(rdA), 32'd150);
        check("t5_keepB", 32'(rdB), 32'd600);
        cycle(0, 0, 0, 480);
        check("t5_oorA", 32'(rdA), 32'd0);
        check("t5_oorB", 32'(rdB), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
